// File: rtl/id_ex_stage.sv
// ID/EX pipeline register sitting between instruction decode and the ALU.
// Captures one decoded instruction per cycle. Operands are resolved by
// forwarding from EX, MEM and WB at capture time. A one-cycle bubble is
// inserted when the instruction being decoded needs a load still held here.
// Downstream backpressure (ex_ready) freezes the slot, and a branch flush
// kills both the held instruction and the one being decoded.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,

  // decode side
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [4:0]         id_alu_function,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_pc,
  input  logic               id_use_imm,
  input  logic               id_use_pc,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_reg_write,
  input  logic               id_mem_read,

  // forwarding sources
  input  logic [XLEN-1:0]    ex_result,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic               mem_reg_write,
  input  logic [XLEN-1:0]    mem_result,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic               wb_reg_write,
  input  logic [XLEN-1:0]    wb_result,

  // ALU side
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [4:0]         alu_function,
  output logic [XLEN-1:0]    operand_a,
  output logic [XLEN-1:0]    operand_b,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read
);

  // Slot occupancy; the slot holds either nothing/a bubble or one instruction.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;

  logic              advance;
  logic              load_use;
  logic              capture;
  logic              ex_fwd_ok;
  logic              rs1_nonzero;
  logic              rs2_nonzero;
  logic              ex_hit_rs1;
  logic              ex_hit_rs2;
  logic              mem_hit_rs1;
  logic              mem_hit_rs2;
  logic              wb_hit_rs1;
  logic              wb_hit_rs2;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;
  logic [XLEN-1:0]   operand_a_next;
  logic [XLEN-1:0]   operand_b_next;

  assign ex_valid = (state == FULL);

  // The slot can take a new entry when it is empty or its occupant leaves.
  assign advance = !ex_valid || ex_ready;

  // A load held here cannot supply its data until MEM, so a dependent
  // instruction must wait one cycle. rs2 only matters when it is not
  // replaced by the immediate.
  assign load_use = ex_valid && ex_mem_read && ex_reg_write &&
                    (ex_rd_addr != '0) &&
                    ((ex_rd_addr == id_rs1_addr) ||
                     ((ex_rd_addr == id_rs2_addr) && !id_use_imm));

  assign id_ready = advance && !load_use && !flush;
  assign capture  = id_valid && id_ready;

  // A held load has no result yet, so EX only forwards ALU producers.
  assign ex_fwd_ok   = ex_valid && ex_reg_write && !ex_mem_read;
  assign rs1_nonzero = (id_rs1_addr != '0);
  assign rs2_nonzero = (id_rs2_addr != '0);

  assign ex_hit_rs1  = ex_fwd_ok     && (ex_rd_addr  == id_rs1_addr) && rs1_nonzero;
  assign ex_hit_rs2  = ex_fwd_ok     && (ex_rd_addr  == id_rs2_addr) && rs2_nonzero;
  assign mem_hit_rs1 = mem_reg_write && (mem_rd_addr == id_rs1_addr) && rs1_nonzero;
  assign mem_hit_rs2 = mem_reg_write && (mem_rd_addr == id_rs2_addr) && rs2_nonzero;
  assign wb_hit_rs1  = wb_reg_write  && (wb_rd_addr  == id_rs1_addr) && rs1_nonzero;
  assign wb_hit_rs2  = wb_reg_write  && (wb_rd_addr  == id_rs2_addr) && rs2_nonzero;

  // Resolve rs1: the youngest producer wins, the register file is the fallback.
  always_comb begin
    // NOTE: assigning a default first gives every path a value, so no latch is inferred.
    fwd_rs1 = id_rs1_data;
    if (ex_hit_rs1) begin
      fwd_rs1 = ex_result;
    end else if (mem_hit_rs1) begin
      fwd_rs1 = mem_result;
    end else if (wb_hit_rs1) begin
      fwd_rs1 = wb_result;
    end
  end

  // Resolve rs2 with the same priority; also feeds store data.
  always_comb begin
    fwd_rs2 = id_rs2_data;
    if (ex_hit_rs2) begin
      fwd_rs2 = ex_result;
    end else if (mem_hit_rs2) begin
      fwd_rs2 = mem_result;
    end else if (wb_hit_rs2) begin
      fwd_rs2 = wb_result;
    end
  end

  // Final ALU operand selection between forwarded registers, PC and immediate.
  always_comb begin
    operand_a_next = id_use_pc  ? id_pc  : fwd_rs1;
    operand_b_next = id_use_imm ? id_imm : fwd_rs2;
  end

  // Pipeline register: reset, then flush, then capture/bubble on advance, else hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state         <= EMPTY;
      alu_function  <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
    end else if (flush) begin
      state         <= EMPTY;
      alu_function  <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
    end else if (advance) begin
      if (capture) begin
        state         <= FULL;
        alu_function  <= id_alu_function;
        operand_a     <= operand_a_next;
        operand_b     <= operand_b_next;
        ex_store_data <= fwd_rs2;
        ex_rd_addr    <= id_rd_addr;
        ex_reg_write  <= id_reg_write;
        ex_mem_read   <= id_mem_read;
      end else begin
        // Nothing accepted: present a bubble that cannot write or load.
        state         <= EMPTY;
        alu_function  <= '0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. A bench-side model of the held slot
// predicts each captured instruction; predictions go into a scoreboard queue
// and are compared when the DUT presents the captured instruction.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } out_t;

  logic        clk = 1'b0;
  logic        reset, flush, id_valid, id_ready;
  logic [4:0]  id_alu_function, id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read;
  logic [31:0] ex_result, mem_result, wb_result;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write, ex_ready;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  alu_function, ex_rd_addr;
  logic [31:0] operand_a, operand_b, ex_store_data;

  int   tests = 0;
  int   fails = 0;
  out_t sb[$];
  out_t m_out;
  out_t exp_o;
  out_t got;
  logic pushed;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_function(id_alu_function),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .alu_function(alu_function),
    .operand_a(operand_a), .operand_b(operand_b), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  function automatic out_t observe();
    out_t o;
    o.valid = ex_valid;      o.fn = alu_function;
    o.a     = operand_a;     o.b  = operand_b;
    o.sd    = ex_store_data; o.rd = ex_rd_addr;
    o.rw    = ex_reg_write;  o.mr = ex_mem_read;
    return o;
  endfunction

  // Later overrides win, so the youngest producer is applied last.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (rs != 5'd0) begin
      if (wb_reg_write && wb_rd_addr == rs)   v = wb_result;
      if (mem_reg_write && mem_rd_addr == rs) v = mem_result;
      if (m_out.valid && m_out.rw && !m_out.mr && m_out.rd == rs) v = ex_result;
    end
    return v;
  endfunction

  function automatic logic model_ready();
    logic adv, lu;
    adv = !m_out.valid || ex_ready;
    lu  = m_out.valid && m_out.mr && m_out.rw && (m_out.rd != 5'd0) &&
          ((m_out.rd == id_rs1_addr) || ((m_out.rd == id_rs2_addr) && !id_use_imm));
    return adv && !lu && !flush;
  endfunction

  function automatic out_t predict();
    out_t e;
    e.valid = 1'b1;
    e.fn    = id_alu_function;
    e.a     = id_use_pc  ? id_pc  : fwd(id_rs1_addr, id_rs1_data);
    e.b     = id_use_imm ? id_imm : fwd(id_rs2_addr, id_rs2_data);
    e.sd    = fwd(id_rs2_addr, id_rs2_data);
    e.rd    = id_rd_addr;
    e.rw    = id_reg_write;
    e.mr    = id_mem_read;
    return e;
  endfunction

  // One clock: update the model from the inputs seen at the edge, then sample 1 time unit later.
  task automatic tick();
    out_t nxt;
    logic rdy;
    rdy    = model_ready();
    nxt    = m_out;
    pushed = 1'b0;
    if (reset) begin
      nxt = '0;
    end else if (flush) begin
      nxt.valid = 1'b0; nxt.fn = 5'd0; nxt.rw = 1'b0; nxt.mr = 1'b0;
    end else if (!m_out.valid || ex_ready) begin
      if (id_valid && rdy) begin
        nxt = predict();
        sb.push_back(nxt);
        pushed = 1'b1;
      end else begin
        nxt.valid = 1'b0; nxt.fn = 5'd0; nxt.rw = 1'b0; nxt.mr = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_out = nxt;
  endtask

  task automatic drive(input logic [4:0] fn, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic ui, input logic up);
    id_valid = 1'b1;   id_alu_function = fn;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr;
    id_rs1_data = d1;  id_rs2_data = d2;  id_imm = imm; id_pc = pc;
    id_use_imm = ui;   id_use_pc = up;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_alu_function = '0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_rd_addr = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_rs1_data = '0;
    id_rs2_data = '0; id_imm = '0; id_pc = '0; id_use_imm = 1'b0; id_use_pc = 1'b0;
  endtask

  task automatic clear_fwd();
    ex_result = '0; mem_rd_addr = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd_addr = '0; wb_reg_write = 1'b0; wb_result = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    idle(); clear_fwd();
    m_out = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    tests++;
    if (observe() !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", observe());
    end
    tests++;
    if (id_ready !== 1'b1) begin
      fails++; $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
    // Fill the slot, stall it, then reset while full.
    drive(5'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h11, 32'h22, 32'h0, 32'h100, 1'b0, 1'b0);
    tick();
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL reset_fill: got %h want %h", got, exp_o); end
    end
    ex_ready = 1'b0; idle();
    tick();
    tests++;
    if (ex_valid !== 1'b1 || operand_a !== 32'h11) begin
      fails++; $display("FAIL reset_hold: got v=%b a=%h want v=1 a=11", ex_valid, operand_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; ex_ready = 1'b1;
    tests++;
    if (observe() !== '0) begin
      fails++; $display("FAIL reset_mid_full: got %h want 0", observe());
    end
  endtask

  task automatic test_ex_forward();
    clear_fwd(); ex_ready = 1'b1;
    drive(5'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h5, 32'h6, 32'h0, 32'h200, 1'b0, 1'b0);
    tick();
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL exfwd_producer: got %h want %h", got, exp_o); end
    end
    ex_result = 32'h10;
    drive(5'd1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 32'hAAAA, 32'hAAAA, 32'h0, 32'h204, 1'b0, 1'b0);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL exfwd_no_stall: got %b want 1", id_ready); end
    tick();
    tests++;
    if (operand_a !== 32'h10 || operand_b !== 32'h10 || ex_valid !== 1'b1) begin
      fails++; $display("FAIL exfwd_operands: got a=%h b=%h v=%b want 10 10 1", operand_a, operand_b, ex_valid);
    end
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL exfwd_sb: got %h want %h", got, exp_o); end
    end
  endtask

  task automatic test_priority();
    clear_fwd(); ex_ready = 1'b1;
    drive(5'd1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h300, 1'b0, 1'b0);
    tick();
    if (pushed) void'(sb.pop_front());
    // EX, MEM and WB all write x5: EX must win.
    ex_result = 32'h1;
    mem_rd_addr = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h2;
    wb_rd_addr  = 5'd5; wb_reg_write  = 1'b1; wb_result  = 32'h3;
    drive(5'd1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 32'h99, 32'h99, 32'h0, 32'h304, 1'b0, 1'b0);
    tick();
    tests++;
    if (operand_a !== 32'h1 || ex_store_data !== 32'h1) begin
      fails++; $display("FAIL prio_ex: got a=%h sd=%h want 1 1", operand_a, ex_store_data);
    end
    if (pushed) void'(sb.pop_front());
    // Held instruction writes x9: MEM beats WB.
    drive(5'd1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 32'h99, 32'h0, 32'h0, 32'h308, 1'b0, 1'b0);
    tick();
    tests++;
    if (operand_a !== 32'h2) begin fails++; $display("FAIL prio_mem: got %h want 2", operand_a); end
    if (pushed) void'(sb.pop_front());
    mem_reg_write = 1'b0;
    drive(5'd1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 32'h99, 32'h0, 32'h0, 32'h30C, 1'b0, 1'b0);
    tick();
    tests++;
    if (operand_a !== 32'h3) begin fails++; $display("FAIL prio_wb: got %h want 3", operand_a); end
    if (pushed) void'(sb.pop_front());
    // Every source writes x0: x0 is never forwarded.
    mem_rd_addr = 5'd0; mem_reg_write = 1'b1; wb_rd_addr = 5'd0; wb_reg_write = 1'b1;
    drive(5'd1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h310, 1'b0, 1'b0);
    tick();
    tests++;
    if (operand_a !== 32'h1234) begin fails++; $display("FAIL prio_x0: got %h want 1234", operand_a); end
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL prio_x0_sb: got %h want %h", got, exp_o); end
    end
  endtask

  task automatic test_load_use();
    clear_fwd(); ex_ready = 1'b1;
    drive(5'd1, 5'd2, 5'd0, 5'd6, 1'b1, 1'b1, 32'h40, 32'h0, 32'h8, 32'h400, 1'b1, 1'b0);
    tick();
    if (pushed) void'(sb.pop_front());
    drive(5'd1, 5'd6, 5'd1, 5'd7, 1'b1, 1'b0, 32'h66, 32'h11, 32'h0, 32'h404, 1'b0, 1'b0);
    tests++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: got %b want 0", id_ready); end
    tick();
    tests++;
    if (ex_valid !== 1'b0 || alu_function !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      fails++; $display("FAIL lu_bubble: got v=%b fn=%h rw=%b mr=%b want 0", ex_valid, alu_function, ex_reg_write, ex_mem_read);
    end
    mem_rd_addr = 5'd6; mem_reg_write = 1'b1; mem_result = 32'hDEADBEEF;
    #1;
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_release: got %b want 1", id_ready); end
    tick();
    tests++;
    if (operand_a !== 32'hDEADBEEF || operand_b !== 32'h11 || ex_valid !== 1'b1) begin
      fails++; $display("FAIL lu_mem_fwd: got a=%h b=%h v=%b want deadbeef 11 1", operand_a, operand_b, ex_valid);
    end
    if (pushed) void'(sb.pop_front());
    clear_fwd();
    // A load feeding only the rs2 field of an immediate instruction does not stall.
    drive(5'd1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b1, 32'h40, 32'h0, 32'h4, 32'h408, 1'b1, 1'b0);
    tick();
    if (pushed) void'(sb.pop_front());
    drive(5'd1, 5'd11, 5'd9, 5'd10, 1'b1, 1'b0, 32'h5, 32'h0, 32'h3, 32'h40C, 1'b1, 1'b0);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_imm_no_stall: got %b want 1", id_ready); end
    tick();
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL lu_imm_sb: got %h want %h", got, exp_o); end
    end
  endtask

  task automatic test_backpressure();
    clear_fwd(); ex_ready = 1'b1;
    drive(5'd3, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'hA1, 32'hB2, 32'h0, 32'h500, 1'b0, 1'b0);
    tick();
    if (pushed) void'(sb.pop_front());
    ex_ready = 1'b0;
    drive(5'd4, 5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 32'hC3, 32'hD4, 32'h0, 32'h504, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (id_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0", i, id_ready); end
      ex_result = $urandom;
      tick();
      tests++;
      if (ex_valid !== 1'b1 || alu_function !== 5'd3 || operand_a !== 32'hA1 ||
          operand_b !== 32'hB2 || ex_rd_addr !== 5'd12) begin
        fails++; $display("FAIL bp_hold_%0d: got %h", i, observe());
      end
    end
    flush = 1'b1;
    #1;
    tests++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL bp_flush_ready: got %b want 0", id_ready); end
    tick();
    flush = 1'b0;
    tests++;
    if (ex_valid !== 1'b0 || alu_function !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      fails++; $display("FAIL bp_flush: got v=%b fn=%h rw=%b mr=%b want 0", ex_valid, alu_function, ex_reg_write, ex_mem_read);
    end
    ex_ready = 1'b1; ex_result = '0;
    tick();
    if (pushed) begin
      exp_o = sb.pop_front(); got = observe(); tests++;
      if (got !== exp_o) begin fails++; $display("FAIL bp_after_flush: got %h want %h", got, exp_o); end
    end
  endtask

  task automatic test_imm();
    clear_fwd(); ex_ready = 1'b1;
    wb_rd_addr = 5'd8; wb_reg_write = 1'b1; wb_result = 32'h7;
    drive(5'd1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 32'h55, 32'h0, 32'hFFFFFFFF, 32'h600, 1'b1, 1'b0);
    tick();
    tests++;
    if (operand_a !== 32'h7 || operand_b !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL imm_addi: got a=%h b=%h want 7 ffffffff", operand_a, operand_b);
    end
    if (pushed) void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      ex_ready      = ($urandom_range(3, 0) != 0);
      ex_result     = $urandom;
      mem_rd_addr   = 5'($urandom_range(3, 0)); mem_reg_write = 1'($urandom); mem_result = $urandom;
      wb_rd_addr    = 5'($urandom_range(3, 0)); wb_reg_write  = 1'($urandom); wb_result  = $urandom;
      drive(5'($urandom_range(11, 1)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
            5'($urandom_range(3, 0)), 1'($urandom), ($urandom_range(3, 0) == 0),
            $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      id_valid = ($urandom_range(4, 0) != 0);
      #1;
      tests++;
      if (id_ready !== model_ready()) begin
        fails++; $display("FAIL b2b_ready_%0d: got %b want %b", i, id_ready, model_ready());
      end
      if (!id_ready) stalls++;
      tick();
      tests++;
      if (ex_valid !== m_out.valid) begin
        fails++; $display("FAIL b2b_valid_%0d: got %b want %b", i, ex_valid, m_out.valid);
      end
      if (pushed) begin
        exp_o = sb.pop_front(); got = observe(); tests++;
        if (got !== exp_o) begin fails++; $display("FAIL b2b_sb_%0d: got %h want %h", i, got, exp_o); end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL b2b_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_backpressure();
    test_imm();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
